// File: rtl/fifo_read_ctrl_if.sv
// rtl/fifo_read_ctrl_if.sv - read-side signal bundle for fifo_read_ctrl
// FIFO_RD_ALMOST_EMPTY_EN adds ralmost_empty to the bundle and both modports.
interface fifo_read_ctrl_if #(
    parameter int DEPTH = 4
);
    logic             rinc;
    logic [DEPTH:0]   wptr_gray;
    logic [DEPTH-1:0] raddr;
    logic [DEPTH:0]   rptr_gray;
    logic             rempty;
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    logic             ralmost_empty;

    modport master (
        output rinc,
        output wptr_gray,
        input  raddr,
        input  rptr_gray,
        input  rempty,
        input  ralmost_empty
    );

    modport slave (
        input  rinc,
        input  wptr_gray,
        output raddr,
        output rptr_gray,
        output rempty,
        output ralmost_empty
    );
`else
    modport master (
        output rinc,
        output wptr_gray,
        input  raddr,
        input  rptr_gray,
        input  rempty
    );

    modport slave (
        input  rinc,
        input  wptr_gray,
        output raddr,
        output rptr_gray,
        output rempty
    );
`endif
endinterface

// File: rtl/fifo_read_ctrl.sv
// rtl/fifo_read_ctrl.sv - dual-clock FIFO read-side pointer, empty flag and write-pointer synchronizer
// FIFO_RD_ALMOST_EMPTY_EN enables AE_THRESH and the registered ralmost_empty flag.
module fifo_read_ctrl #(
    parameter int DEPTH = 4
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    ,
    parameter int AE_THRESH = 1
`endif
) (
    input  logic             rclk,
    input  logic             rrst,
    fifo_read_ctrl_if.slave  rd
);
    logic [DEPTH:0] rq1;
    logic [DEPTH:0] rq2;
    logic [DEPTH:0] rbin;
    logic [DEPTH:0] rgray;
    logic [DEPTH:0] rbin_next;
    logic [DEPTH:0] rgray_next;
    logic           rpop;
    logic           rempty_q;

    // Two-flop crossing; Gray coding guarantees at most one bit in flight.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            rq1 <= '0;
            rq2 <= '0;
        end else begin
            rq1 <= rd.wptr_gray;
            rq2 <= rq1;
        end
    end

    assign rpop       = rd.rinc & ~rempty_q;
    assign rbin_next  = rbin + {{DEPTH{1'b0}}, rpop};
    assign rgray_next = (rbin_next >> 1) ^ rbin_next;

    // Empty compares against the look-ahead pointer so a pop of the last entry
    // flags empty on the same edge; the stale rq2 keeps it pessimistic.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            rbin     <= '0;
            rgray    <= '0;
            rempty_q <= 1'b1;
        end else begin
            rbin     <= rbin_next;
            rgray    <= rgray_next;
            rempty_q <= (rgray_next == rq2);
        end
    end

    assign rd.raddr     = rbin[DEPTH-1:0];
    assign rd.rptr_gray = rgray;
    assign rd.rempty    = rempty_q;

`ifdef FIFO_RD_ALMOST_EMPTY_EN
    localparam logic [DEPTH:0] AE_LEVEL = AE_THRESH[DEPTH:0];

    logic [DEPTH:0] wbin_sync;
    logic [DEPTH:0] level_next;
    logic           ralmost_empty_q;

    function automatic logic [DEPTH:0] gray2bin(input logic [DEPTH:0] g);
        logic [DEPTH:0] b;
        b[DEPTH] = g[DEPTH];
        for (int i = DEPTH - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign wbin_sync  = gray2bin(rq2);
    assign level_next = wbin_sync - rbin_next;

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            ralmost_empty_q <= 1'b1;
        end else begin
            ralmost_empty_q <= (level_next <= AE_LEVEL);
        end
    end

    assign rd.ralmost_empty = ralmost_empty_q;
`endif
endmodule

// File: tb/tb_fifo_read_ctrl.sv
// tb/tb_fifo_read_ctrl.sv - self-checking bench for fifo_read_ctrl
// FIFO_RD_ALMOST_EMPTY_EN additionally checks ralmost_empty.
module tb_fifo_read_ctrl;
    localparam int DEPTH     = 4;
    localparam int AE_THRESH = 1;
    localparam int MOD       = 32;

    logic rclk   = 1'b0;
    logic rrst   = 1'b0;
    bit   clk_en = 1'b0;

    fifo_read_ctrl_if #(.DEPTH(DEPTH)) rd_if ();

    fifo_read_ctrl #(
        .DEPTH(DEPTH)
`ifdef FIFO_RD_ALMOST_EMPTY_EN
        ,
        .AE_THRESH(AE_THRESH)
`endif
    ) dut (
        .rclk(rclk),
        .rrst(rrst),
        .rd  (rd_if)
    );

    always begin
        #5;
        if (clk_en) rclk = ~rclk;
    end

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: counts of entries written and read, plus the write
    // counts as observed at each read edge.
    int w;
    int m_r;
    bit m_empty;
    bit m_ae;
    int seen_q[$];

    typedef struct {
        bit         rinc;
        int         wbin;
        int         raddr;
        logic [4:0] gray;
        bit         empty;
    } vec_t;

    vec_t tbl[9];

    function automatic logic [4:0] gray(input int b);
        logic [4:0] v;
        v = b[4:0];
        return v ^ (v >> 1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_r     = 0;
        m_empty = 1'b1;
        m_ae    = 1'b1;
        seen_q  = {0, 0};
    endtask

    task automatic drive(input bit inc);
        rd_if.rinc      = inc;
        rd_if.wptr_gray = gray(w);
    endtask

    task automatic tick();
        int w_pre;
        int old;
        int lvl;
        bit pop;
        pop   = rd_if.rinc && !m_empty;
        w_pre = w;
        @(posedge rclk);
        #1;
        old = seen_q.pop_front();
        seen_q.push_back(w_pre);
        if (pop) m_r = (m_r + 1) % MOD;
        m_empty = (m_r == old);
        lvl     = (old - m_r + MOD) % MOD;
        m_ae    = (lvl <= AE_THRESH);
        check("model_raddr", {28'd0, rd_if.raddr}, m_r % 16);
        check("model_rptr_gray", {27'd0, rd_if.rptr_gray}, {27'd0, gray(m_r)});
        check("model_rempty", {31'd0, rd_if.rempty}, {31'd0, m_empty});
`ifdef FIFO_RD_ALMOST_EMPTY_EN
        check("model_ralmost_empty", {31'd0, rd_if.ralmost_empty}, {31'd0, m_ae});
`endif
    endtask

    // Called just after an edge; both sides reset together, released mid-cycle.
    task automatic do_reset();
        rrst = 1'b1;
        w    = 0;
        drive(1'b0);
        #2;
        rrst = 1'b0;
        model_reset();
    endtask

    initial begin
        tbl[0] = '{1'b0, 1, 0, 5'b00000, 1'b1};
        tbl[1] = '{1'b0, 1, 0, 5'b00000, 1'b1};
        tbl[2] = '{1'b0, 1, 0, 5'b00000, 1'b0};
        tbl[3] = '{1'b1, 1, 1, 5'b00001, 1'b1};
        for (int i = 4; i < 9; i++) tbl[i] = '{1'b1, 1, 1, 5'b00001, 1'b1};

        w = 0;
        drive(1'b0);
        #2;
        rrst = 1'b1;
        #1;
        check("reset_rempty", {31'd0, rd_if.rempty}, 32'd1);
        check("reset_raddr", {28'd0, rd_if.raddr}, 32'd0);
        check("reset_rptr_gray", {27'd0, rd_if.rptr_gray}, 32'd0);
`ifdef FIFO_RD_ALMOST_EMPTY_EN
        check("reset_ralmost_empty", {31'd0, rd_if.ralmost_empty}, 32'd1);
`endif
        clk_en = 1'b1;
        @(posedge rclk);
        #1;
        rrst = 1'b0;
        model_reset();

        // Write visibility, single pop, then underflow guard.
        for (int i = 0; i < 9; i++) begin
            w = tbl[i].wbin;
            drive(tbl[i].rinc);
            tick();
            check("tbl_raddr", {28'd0, rd_if.raddr}, tbl[i].raddr);
            check("tbl_rptr_gray", {27'd0, rd_if.rptr_gray}, {27'd0, tbl[i].gray});
            check("tbl_rempty", {31'd0, rd_if.rempty}, {31'd0, tbl[i].empty});
        end

        // Wrap: full range of 16 entries drained back to back.
        do_reset();
        w = 16;
        drive(1'b0);
        repeat (3) tick();
        check("wrap_ready", {31'd0, rd_if.rempty}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            check("wrap_raddr_seq", {28'd0, rd_if.raddr}, i);
            drive(1'b1);
            tick();
            check("wrap_rempty", {31'd0, rd_if.rempty}, (i == 15) ? 32'd1 : 32'd0);
        end
        drive(1'b0);
        check("wrap_raddr_end", {28'd0, rd_if.raddr}, 32'd0);
        check("wrap_rptr_gray", {27'd0, rd_if.rptr_gray}, 32'b11000);

        // Asynchronous reset between edges after 7 pops.
        do_reset();
        w = 16;
        drive(1'b0);
        repeat (3) tick();
        drive(1'b1);
        repeat (7) tick();
        check("mid_raddr_before", {28'd0, rd_if.raddr}, 32'd7);
        drive(1'b0);
        #1;
        rrst = 1'b1;
        #1;
        check("mid_reset_raddr", {28'd0, rd_if.raddr}, 32'd0);
        check("mid_reset_rptr_gray", {27'd0, rd_if.rptr_gray}, 32'd0);
        check("mid_reset_rempty", {31'd0, rd_if.rempty}, 32'd1);
        w = 0;
        drive(1'b0);
        #1;
        rrst = 1'b0;
        model_reset();
        w = 2;
        drive(1'b0);
        repeat (3) tick();
        check("post_reset_ready", {31'd0, rd_if.rempty}, 32'd0);
        drive(1'b1);
        tick();
        check("post_reset_pop", {28'd0, rd_if.raddr}, 32'd1);

`ifdef FIFO_RD_ALMOST_EMPTY_EN
        do_reset();
        w = 3;
        drive(1'b0);
        repeat (3) tick();
        check("ae_three", {31'd0, rd_if.ralmost_empty}, 32'd0);
        drive(1'b1);
        tick();
        check("ae_pop1", {31'd0, rd_if.ralmost_empty}, 32'd0);
        tick();
        check("ae_pop2", {31'd0, rd_if.ralmost_empty}, 32'd1);
        tick();
        check("ae_pop3_empty", {31'd0, rd_if.rempty}, 32'd1);
        drive(1'b0);
`endif

        // Random writes and reads against the model; writer never overfills.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 1) == 1 && ((w - m_r + MOD) % MOD) < 16) w = (w + 1) % MOD;
            drive($urandom_range(0, 2) != 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
